// File: rtl/bp_me_nonsynth_mock_lce_pkg.sv
// Shared types for the mock LCE: processor configuration, bedrock LCE
// command/response message headers, message enums and small helpers.
package bp_me_nonsynth_mock_lce_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 512;
  localparam int dword_width_gp    = 64;
  localparam int lce_id_width_p    = 4;
  localparam int cce_id_width_p    = 4;
  localparam int lce_assoc_p       = 8;
  // One spare bit so that an out-of-range way can be expressed and flagged.
  localparam int way_id_width_p    = 4;

  localparam int beats_lp              = cce_block_width_p / dword_width_gp;
  localparam int beat_width_lp         = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int block_offset_width_lp = $clog2(cce_block_width_p / 8);

  typedef enum logic [3:0] {
    e_bedrock_cmd_sync        = 4'd0,
    e_bedrock_cmd_st_wakeup   = 4'd1,
    e_bedrock_cmd_inv         = 4'd2,
    e_bedrock_cmd_st          = 4'd3,
    e_bedrock_cmd_data        = 4'd4,
    e_bedrock_cmd_uc_data     = 4'd5,
    e_bedrock_cmd_uc_st_done  = 4'd6,
    e_bedrock_cmd_st_wb       = 4'd7,
    e_bedrock_cmd_wb          = 4'd8,
    e_bedrock_cmd_st_tr       = 4'd9,
    e_bedrock_cmd_st_tr_wb    = 4'd10
  } bp_bedrock_cmd_type_e;

  typedef enum logic [2:0] {
    e_bedrock_resp_sync_ack = 3'd0,
    e_bedrock_resp_inv_ack  = 3'd1,
    e_bedrock_resp_coh_ack  = 3'd2,
    e_bedrock_resp_wb       = 3'd3,
    e_bedrock_resp_null_wb  = 3'd4
  } bp_bedrock_resp_type_e;

  typedef enum logic [2:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_F = 3'd3,
    e_COH_O = 3'd6,
    e_COH_M = 3'd7
  } bp_coh_states_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    bp_coh_states_e              state;
    logic [way_id_width_p-1:0]   way_id;
    logic [cce_id_width_p-1:0]   src_id;
    logic [lce_id_width_p-1:0]   dst_id;
    logic [2:0]                  size;
    logic [paddr_width_p-1:0]    addr;
    bp_bedrock_cmd_type_e        msg_type;
  } bp_bedrock_lce_cmd_header_s;

  typedef struct packed {
    logic [lce_id_width_p-1:0]   src_id;
    logic [cce_id_width_p-1:0]   dst_id;
    logic [2:0]                  size;
    logic [paddr_width_p-1:0]    addr;
    bp_bedrock_resp_type_e       msg_type;
  } bp_bedrock_lce_resp_header_s;

  localparam int lce_cmd_msg_header_width_lp  = $bits(bp_bedrock_lce_cmd_header_s);
  localparam int lce_resp_msg_header_width_lp = $bits(bp_bedrock_lce_resp_header_s);

  function automatic int cfg_lce_assoc(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: cfg_lce_assoc = lce_assoc_p;
      default:          cfg_lce_assoc = lce_assoc_p;
    endcase
  endfunction

  function automatic logic [paddr_width_p-1:0] block_align(input logic [paddr_width_p-1:0] addr);
    block_align = {addr[paddr_width_p-1:block_offset_width_lp], {block_offset_width_lp{1'b0}}};
  endfunction

  // Writeback beat k carries the low 32 address bits and the beat index.
  function automatic logic [dword_width_gp-1:0] wb_beat(input logic [paddr_width_p-1:0] addr,
                                                        input logic [beat_width_lp-1:0] k);
    logic [paddr_width_p-1:0] aligned;
    aligned = block_align(addr);
    wb_beat = {aligned[31:0], 32'(k)};
  endfunction

endpackage

// File: rtl/bp_me_nonsynth_mock_lce_counter.sv
// Beat counter with synchronous clear and increment; clear wins over up.
module bp_me_nonsynth_mock_lce_counter #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r;

  // Count register: async active-low reset, clear to zero, else step up.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (up_i) begin
      count_r <= count_r + width_p'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bp_me_nonsynth_mock_lce.sv
// Mock LCE: accepts CCE commands, tracks per-way dirty bits and answers
// with acks and (null) writebacks so a CCE can run without a real cache.
module bp_me_nonsynth_mock_lce
  import bp_me_nonsynth_mock_lce_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [lce_id_width_p-1:0]               lce_id_i,
  input  logic [lce_cmd_msg_header_width_lp-1:0]  lce_cmd_header_i,
  input  logic                                    lce_cmd_header_v_i,
  output logic                                    lce_cmd_header_ready_and_o,
  input  logic [dword_width_gp-1:0]               lce_cmd_data_i,
  input  logic                                    lce_cmd_data_v_i,
  output logic                                    lce_cmd_data_ready_and_o,
  output logic [lce_resp_msg_header_width_lp-1:0] lce_resp_header_o,
  output logic                                    lce_resp_header_v_o,
  input  logic                                    lce_resp_header_ready_and_i,
  output logic [dword_width_gp-1:0]               lce_resp_data_o,
  output logic                                    lce_resp_data_v_o,
  input  logic                                    lce_resp_data_ready_and_i,
  output logic                                    error_o,
  output logic [31:0]                             cmd_count_o
);

  localparam int lce_assoc_lp     = cfg_lce_assoc(bp_params_p);
  localparam int way_idx_width_lp = $clog2(lce_assoc_lp);
  localparam logic [way_id_width_p-1:0] way_limit_lp = way_id_width_p'(lce_assoc_lp);
  localparam logic [beat_width_lp-1:0]  last_beat_lp = beat_width_lp'(beats_lp - 1);

  typedef enum logic [1:0] {
    e_ready     = 2'd0,
    e_cmd_data  = 2'd1,
    e_resp_hdr  = 2'd2,
    e_resp_data = 2'd3
  } state_e;

  state_e                      state_r, state_n;
  bp_bedrock_lce_cmd_header_s  cmd_hdr_s;
  bp_bedrock_lce_resp_header_s resp_hdr_r, resp_hdr_n;
  bp_bedrock_resp_type_e       resp_type_s;
  bp_bedrock_cmd_type_e        cmd_type_r;

  logic                        hdr_ready_r, data_ready_r, resp_v_r, resp_data_v_r, error_r;
  logic [dword_width_gp-1:0]   resp_data_r;
  logic [lce_assoc_lp-1:0]     dirty_r, dirty_n;
  logic [31:0]                 cmd_count_r;

  logic                        cmd_hs_s, cmd_data_hs_s, resp_hdr_hs_s, resp_data_hs_s;
  logic                        beat_hs_s, last_beat_s, cnt_clear_s, cnt_up_s;
  logic                        cmd_known_s, cmd_ok_s, way_ok_s;
  logic [way_idx_width_lp-1:0] way_idx_s;
  logic [beat_width_lp-1:0]    beat_cnt_s, beat_next_s;
  logic                        unused_s;

  assign cmd_hdr_s      = lce_cmd_header_i;
  assign cmd_hs_s       = lce_cmd_header_v_i & hdr_ready_r;
  assign cmd_data_hs_s  = lce_cmd_data_v_i & data_ready_r;
  assign resp_hdr_hs_s  = resp_v_r & lce_resp_header_ready_and_i;
  assign resp_data_hs_s = resp_data_v_r & lce_resp_data_ready_and_i;
  assign beat_hs_s      = cmd_data_hs_s | resp_data_hs_s;
  assign last_beat_s    = (beat_cnt_s == last_beat_lp);
  assign cnt_clear_s    = beat_hs_s & last_beat_s;
  assign cnt_up_s       = beat_hs_s & ~last_beat_s;

  assign way_idx_s = cmd_hdr_s.way_id[way_idx_width_lp-1:0];
  assign way_ok_s  = (cmd_hdr_s.way_id < way_limit_lp);
  assign cmd_ok_s  = cmd_known_s & (cmd_hdr_s.dst_id == lce_id_i) & way_ok_s;

  // Command payload and size are never inspected by this mock.
  assign unused_s = ^{lce_cmd_data_i, cmd_hdr_s.size};

  bp_me_nonsynth_mock_lce_counter #(
    .width_p (beat_width_lp)
  ) beat_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clear_s),
    .up_i    (cnt_up_s),
    .count_o (beat_cnt_s)
  );

  // Beat index the counter will hold after this edge, used to preload data.
  always_comb begin
    beat_next_s = beat_cnt_s;
    if (cnt_clear_s) begin
      beat_next_s = '0;
    end else if (cnt_up_s) begin
      beat_next_s = beat_cnt_s + beat_width_lp'(1);
    end else begin
      beat_next_s = beat_cnt_s;
    end
  end

  // Classify the incoming command and pick the response type it earns.
  always_comb begin
    cmd_known_s = 1'b0;
    resp_type_s = e_bedrock_resp_coh_ack;
    case (cmd_hdr_s.msg_type)
      e_bedrock_cmd_sync: begin
        cmd_known_s = 1'b1;
        resp_type_s = e_bedrock_resp_sync_ack;
      end
      e_bedrock_cmd_inv: begin
        cmd_known_s = 1'b1;
        resp_type_s = e_bedrock_resp_inv_ack;
      end
      e_bedrock_cmd_st, e_bedrock_cmd_st_wakeup,
      e_bedrock_cmd_data, e_bedrock_cmd_uc_data: begin
        cmd_known_s = 1'b1;
        resp_type_s = e_bedrock_resp_coh_ack;
      end
      e_bedrock_cmd_wb, e_bedrock_cmd_st_wb: begin
        cmd_known_s = 1'b1;
        if (dirty_r[way_idx_s]) begin
          resp_type_s = e_bedrock_resp_wb;
        end else begin
          resp_type_s = e_bedrock_resp_null_wb;
        end
      end
      default: begin
        cmd_known_s = 1'b0;
        resp_type_s = e_bedrock_resp_coh_ack;
      end
    endcase
  end

  // Build the response header: reply to the sender, block-aligned address.
  always_comb begin
    resp_hdr_n          = '0;
    resp_hdr_n.msg_type = resp_type_s;
    resp_hdr_n.addr     = block_align(cmd_hdr_s.addr);
    resp_hdr_n.dst_id   = cmd_hdr_s.src_id;
    resp_hdr_n.src_id   = lce_id_i;
    if (resp_type_s == e_bedrock_resp_wb) begin
      resp_hdr_n.size = e_bedrock_msg_size_64;
    end else begin
      resp_hdr_n.size = e_bedrock_msg_size_1;
    end
  end

  // Dirty tracking: only an M fill dirties a way; every writeback cleans it.
  always_comb begin
    dirty_n = dirty_r;
    if (cmd_hs_s && cmd_ok_s) begin
      case (cmd_hdr_s.msg_type)
        e_bedrock_cmd_inv, e_bedrock_cmd_wb, e_bedrock_cmd_st_wb: begin
          dirty_n[way_idx_s] = 1'b0;
        end
        e_bedrock_cmd_st, e_bedrock_cmd_st_wakeup: begin
          if (cmd_hdr_s.state != e_COH_M) begin
            dirty_n[way_idx_s] = 1'b0;
          end else begin
            dirty_n[way_idx_s] = dirty_r[way_idx_s];
          end
        end
        e_bedrock_cmd_data: begin
          dirty_n[way_idx_s] = (cmd_hdr_s.state == e_COH_M);
        end
        default: begin
          dirty_n = dirty_r;
        end
      endcase
    end else begin
      dirty_n = dirty_r;
    end
  end

  // Next-state logic for the command / response sequencing FSM.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready: begin
        if (cmd_hs_s && cmd_ok_s) begin
          case (cmd_hdr_s.msg_type)
            e_bedrock_cmd_sync, e_bedrock_cmd_inv,
            e_bedrock_cmd_wb, e_bedrock_cmd_st_wb:     state_n = e_resp_hdr;
            e_bedrock_cmd_data, e_bedrock_cmd_uc_data: state_n = e_cmd_data;
            default:                                   state_n = e_ready;
          endcase
        end else begin
          state_n = e_ready;
        end
      end
      e_cmd_data: begin
        if (cmd_data_hs_s && last_beat_s) begin
          if (cmd_type_r == e_bedrock_cmd_data) begin
            state_n = e_resp_hdr;
          end else begin
            state_n = e_ready;
          end
        end else begin
          state_n = e_cmd_data;
        end
      end
      e_resp_hdr: begin
        if (resp_hdr_hs_s) begin
          if (resp_hdr_r.msg_type == e_bedrock_resp_wb) begin
            state_n = e_resp_data;
          end else begin
            state_n = e_ready;
          end
        end else begin
          state_n = e_resp_hdr;
        end
      end
      e_resp_data: begin
        if (resp_data_hs_s && last_beat_s) begin
          state_n = e_ready;
        end else begin
          state_n = e_resp_data;
        end
      end
      default: state_n = e_ready;
    endcase
  end

  // State, registered handshake outputs, dirty bits, error and command count.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r       <= e_ready;
      hdr_ready_r   <= 1'b0;
      data_ready_r  <= 1'b0;
      resp_v_r      <= 1'b0;
      resp_data_v_r <= 1'b0;
      resp_data_r   <= '0;
      resp_hdr_r    <= '0;
      cmd_type_r    <= e_bedrock_cmd_sync;
      dirty_r       <= '0;
      error_r       <= 1'b0;
      cmd_count_r   <= '0;
    end else begin
      state_r       <= state_n;
      hdr_ready_r   <= (state_n == e_ready);
      data_ready_r  <= (state_n == e_cmd_data);
      resp_v_r      <= (state_n == e_resp_hdr);
      resp_data_v_r <= (state_n == e_resp_data);
      resp_data_r   <= (state_n == e_resp_data) ? wb_beat(resp_hdr_r.addr, beat_next_s) : '0;
      dirty_r       <= dirty_n;
      if (cmd_hs_s && cmd_ok_s) begin
        resp_hdr_r <= resp_hdr_n;
        cmd_type_r <= cmd_hdr_s.msg_type;
      end
      if (cmd_hs_s && !cmd_ok_s) begin
        error_r <= 1'b1;
      end
      if (cmd_hs_s && (cmd_count_r != 32'hFFFF_FFFF)) begin
        cmd_count_r <= cmd_count_r + 32'd1;
      end
    end
  end

  assign lce_cmd_header_ready_and_o = hdr_ready_r;
  assign lce_cmd_data_ready_and_o   = data_ready_r;
  assign lce_resp_header_o          = resp_hdr_r;
  assign lce_resp_header_v_o        = resp_v_r;
  assign lce_resp_data_o            = resp_data_r;
  assign lce_resp_data_v_o          = resp_data_v_r;
  assign error_o                    = error_r;
  assign cmd_count_o                = cmd_count_r;

endmodule
